// File: rtl/gcm_ghash_ds_if.sv
// Handshake and data bus for the digit-serial GHASH engine.
// The host drives init/next/data; the engine returns Y, ready and the block count.
interface gcm_ghash_ds_if #(parameter int CNT_W = 32);
  logic             init;
  logic             next;
  logic [127:0]     h0;
  logic [127:0]     x;
  logic [4:0]       x_bytes;
  logic [127:0]     y;
  logic             ready;
  logic [CNT_W-1:0] blk_cnt;

  modport master (output init, next, h0, x, x_bytes, input  y, ready, blk_cnt);
  modport slave  (input  init, next, h0, x, x_bytes, output y, ready, blk_cnt);
endinterface

// File: rtl/gcm_ghash_ds.sv
// Digit-serial GHASH: Y <= (Y ^ X) * H in GF(2^128), bit-reflected GCM convention,
// DIGIT_BITS multiplier bits per cycle, 128/DIGIT_BITS cycles per block.
module gcm_ghash_ds #(
  parameter int DIGIT_BITS = 8,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  gcm_ghash_ds_if.slave   bus
);
  localparam int NDIG = 128 / DIGIT_BITS;
  localparam int DCW  = $clog2(NDIG + 1);
  localparam logic [127:0] R = {8'hE1, 120'd0};

  typedef enum logic {IDLE, MULT} state_e;

  state_e           state_q, state_d;
  logic [127:0]     h_q, h_d, m_q, m_d, z_q, z_d, v_q, v_d, y_q, y_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     x_mask, z_step, v_step;
  logic [4:0]       nbytes;

  // Out-of-range byte counts mean a full block.
  always_comb begin
    x_mask = '0;
    nbytes = (bus.x_bytes == 5'd0 || bus.x_bytes > 5'd16) ? 5'd16 : bus.x_bytes;
    for (int b = 0; b < 16; b++)
      x_mask[127-8*b -: 8] = (b < int'(nbytes)) ? bus.x[127-8*b -: 8] : 8'h00;
  end

  // DIGIT_BITS shift-and-add steps, multiplier consumed MSB first from m_q.
  always_comb begin
    z_step = z_q;
    v_step = v_q;
    for (int i = 0; i < DIGIT_BITS; i++) begin
      if (m_q[127-i]) z_step = z_step ^ v_step;
      v_step = v_step[0] ? ((v_step >> 1) ^ R) : (v_step >> 1);
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    z_d     = z_q;
    v_d     = v_q;
    y_d     = y_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    if (bus.init) begin
      // init overrides everything, including a concurrent next or a multiply in flight
      h_d     = bus.h0;
      y_d     = '0;
      cnt_d   = '0;
      dcnt_d  = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.next) begin
          m_d     = y_q ^ x_mask;
          z_d     = '0;
          v_d     = h_q;
          dcnt_d  = DCW'(NDIG);
          state_d = MULT;
        end
        MULT: begin
          z_d    = z_step;
          v_d    = v_step;
          m_d    = m_q << DIGIT_BITS;
          dcnt_d = dcnt_q - DCW'(1);
          if (dcnt_q == DCW'(1)) begin
            y_d     = z_step;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      m_q     <= '0;
      z_q     <= '0;
      v_q     <= '0;
      y_q     <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      z_q     <= z_d;
      v_q     <= v_d;
      y_q     <= y_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.ready   = (state_q == IDLE);
  assign bus.blk_cnt = cnt_q;
endmodule

// File: tb/tb_gcm_ghash_ds.sv
// Bench for gcm_ghash_ds: directed cases on the default build, then a random
// sweep over DIGIT_BITS 8/1/4/16 against a polynomial-arithmetic GF(2^128) model.
module tb_gcm_ghash_ds;
  localparam int DBS [4] = '{8, 1, 4, 16};
  localparam logic [127:0] ONE_H = {1'b1, 127'd0};

  logic clk, reset_n;
  logic [3:0]        init_a, next_a, ready_a;
  logic [3:0][127:0] h0_a, x_a, y_a;
  logic [3:0][4:0]   xb_a;
  logic [3:0][31:0]  cnt_a;
  int checks = 0, errors = 0;

  gcm_ghash_ds_if #(.CNT_W(32)) bi [4] ();
  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign bi[g].init    = init_a[g];
    assign bi[g].next    = next_a[g];
    assign bi[g].h0      = h0_a[g];
    assign bi[g].x       = x_a[g];
    assign bi[g].x_bytes = xb_a[g];
    assign y_a[g]        = bi[g].y;
    assign ready_a[g]    = bi[g].ready;
    assign cnt_a[g]      = bi[g].blk_cnt;
    gcm_ghash_ds #(.DIGIT_BITS(DBS[g]), .CNT_W(32)) u_dut (.clk(clk), .reset_n(reset_n), .bus(bi[g]));
  end

  // Narrow counter instance to reach saturation quickly.
  gcm_ghash_ds_if #(.CNT_W(2)) sat_if ();
  gcm_ghash_ds #(.DIGIT_BITS(16), .CNT_W(2)) u_sat (.clk(clk), .reset_n(reset_n), .bus(sat_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] rev(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Carry-less product of the natural-order polynomials, reduced by x^128+x^7+x^2+x+1.
  function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p, pa, pb, poly;
    pa = {127'd0, rev(a)};
    pb = {127'd0, rev(b)};
    p  = '0;
    for (int i = 0; i < 128; i++) if (pa[i]) p = p ^ (pb << i);
    poly = '0;
    poly[128] = 1'b1; poly[7] = 1'b1; poly[2] = 1'b1; poly[1] = 1'b1; poly[0] = 1'b1;
    for (int i = 254; i >= 128; i--) if (p[i]) p = p ^ (poly << (i - 128));
    return rev(p[127:0]);
  endfunction

  function automatic logic [127:0] mask_ref(input logic [127:0] x, input int nb);
    logic [127:0] all1;
    all1 = '1;
    if (nb == 0 || nb > 16) nb = 16;
    return x & ~(all1 >> (8 * nb));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init(input int k, input logic [127:0] h);
    init_a[k] = 1'b1;
    h0_a[k]   = h;
    tick();
    init_a[k] = 1'b0;
  endtask

  task automatic start(input int k, input logic [127:0] x, input logic [4:0] xb);
    x_a[k]    = x;
    xb_a[k]   = xb;
    next_a[k] = 1'b1;
    tick();
    next_a[k] = 1'b0;
  endtask

  // Counts edges from the accepting edge until ready returns; flags any y change meanwhile.
  task automatic wait_done(input int k, output int lat, output logic held);
    logic [127:0] y0;
    lat  = 0;
    held = 1'b1;
    y0   = y_a[k];
    while (!ready_a[k] && lat < 300) begin
      if (y_a[k] !== y0) held = 1'b0;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic held;
    logic [127:0] a, b, hk, xk;
    logic [4:0] xbk;
    logic [3:0][127:0] ym, hm;
    int cm [4];
    int lt [4];
    logic [3:0] act, done;
    int c;

    reset_n = 1'b0;
    init_a = '0; next_a = '0; h0_a = '0; x_a = '0; xb_a = '0;
    sat_if.init = 1'b0; sat_if.next = 1'b0; sat_if.h0 = '0; sat_if.x = '0; sat_if.x_bytes = '0;
    tick(); tick();
    chk("rst_y", y_a[0], '0);
    chk("rst_ready", {127'd0, ready_a[0]}, 128'd1);
    chk("rst_cnt", {96'd0, cnt_a[0]}, '0);
    reset_n = 1'b1;
    tick(); tick();
    chk("post_rst_y", y_a[0], '0);
    chk("post_rst_ready", {127'd0, ready_a[0]}, 128'd1);

    // Identity key
    pulse_init(0, ONE_H);
    a = 128'h0123456789ABCDEF0011223344556677;
    start(0, a, 5'd16);
    chk("busy_ready", {127'd0, ready_a[0]}, '0);
    wait_done(0, lat, held);
    chk("id_lat", 128'(lat), 128'd16);
    chk("id_hold", {127'd0, held}, 128'd1);
    chk("id_y", y_a[0], a);
    chk("id_cnt", {96'd0, cnt_a[0]}, 128'd1);

    // Reduction: x * x^127 = x^128
    pulse_init(0, {2'b01, 126'd0});
    start(0, 128'd1, 5'd16);
    wait_done(0, lat, held);
    chk("red_y", y_a[0], {8'hE1, 120'd0});

    // Partial blocks
    pulse_init(0, ONE_H);
    start(0, '1, 5'd3);
    wait_done(0, lat, held);
    chk("part3_y", y_a[0], {24'hFFFFFF, 104'd0});
    pulse_init(0, ONE_H);
    start(0, '1, 5'd0);
    wait_done(0, lat, held);
    chk("part0_y", y_a[0], '1);

    // Chaining with a next dropped while busy
    a = rnd128(); b = rnd128();
    pulse_init(0, ONE_H);
    start(0, a, 5'd16);
    tick(); tick();
    start(0, rnd128(), 5'd16);
    wait_done(0, lat, held);
    chk("chain_first_y", y_a[0], a);
    start(0, b, 5'd16);
    wait_done(0, lat, held);
    chk("chain_y", y_a[0], a ^ b);
    chk("chain_cnt", {96'd0, cnt_a[0]}, 128'd2);

    // init aborts a multiply in flight
    start(0, rnd128(), 5'd16);
    for (int i = 0; i < 5; i++) tick();
    pulse_init(0, ONE_H);
    chk("abort_ready", {127'd0, ready_a[0]}, 128'd1);
    chk("abort_y", y_a[0], '0);
    chk("abort_cnt", {96'd0, cnt_a[0]}, '0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_y_later", y_a[0], '0);

    // init and next together: next dropped
    start(0, a, 5'd16);
    wait_done(0, lat, held);
    init_a[0] = 1'b1; h0_a[0] = ONE_H; next_a[0] = 1'b1; x_a[0] = b;
    tick();
    init_a[0] = 1'b0; next_a[0] = 1'b0;
    chk("both_ready", {127'd0, ready_a[0]}, 128'd1);
    chk("both_y", y_a[0], '0);
    chk("both_cnt", {96'd0, cnt_a[0]}, '0);
    tick();
    chk("both_ready2", {127'd0, ready_a[0]}, 128'd1);

    // Asynchronous reset mid-multiply
    start(0, a, 5'd16);
    wait_done(0, lat, held);
    start(0, b, 5'd16);
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_y", y_a[0], '0);
    chk("arst_ready", {127'd0, ready_a[0]}, 128'd1);
    chk("arst_cnt", {96'd0, cnt_a[0]}, '0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("arst_y_later", y_a[0], '0);

    // Counter saturation on the 2-bit instance
    sat_if.init = 1'b1; sat_if.h0 = ONE_H;
    tick();
    sat_if.init = 1'b0;
    for (int j = 0; j < 5; j++) begin
      sat_if.x = rnd128(); sat_if.x_bytes = 5'd16; sat_if.next = 1'b1;
      tick();
      sat_if.next = 1'b0;
      c = 0;
      while (!sat_if.ready && c < 20) begin tick(); c++; end
      chk("sat_cnt", {126'd0, sat_if.blk_cnt}, 128'((j + 1 > 3) ? 3 : j + 1));
    end

    // Random sweep; DIGIT_BITS=1 joins only the first 200 blocks to bound run time
    ym = '0; hm = '0;
    for (int k = 0; k < 4; k++) cm[k] = 0;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 4; k++) act[k] = (k != 1) || (i < 200);
      if (i % 8 == 0) begin
        hk = rnd128();
        for (int k = 0; k < 4; k++) if (act[k]) begin
          init_a[k] = 1'b1; h0_a[k] = hk; ym[k] = '0; hm[k] = hk; cm[k] = 0;
        end
        tick();
        init_a = '0;
      end
      xk  = rnd128();
      xbk = 5'($urandom_range(0, 31));
      for (int k = 0; k < 4; k++) if (act[k]) begin
        x_a[k] = xk; xb_a[k] = xbk; next_a[k] = 1'b1;
      end
      tick();
      next_a = '0;
      done = ~act;
      for (int k = 0; k < 4; k++) lt[k] = -1;
      c = 0;
      while (done != 4'hF && c < 200) begin
        tick();
        c++;
        for (int k = 0; k < 4; k++) if (!done[k] && ready_a[k]) begin
          lt[k] = c; done[k] = 1'b1;
        end
      end
      for (int k = 0; k < 4; k++) if (act[k]) begin
        ym[k] = gmul(ym[k] ^ mask_ref(xk, int'(xbk)), hm[k]);
        cm[k]++;
        chk($sformatf("sweep_lat_d%0d", DBS[k]), 128'(lt[k]), 128'(128 / DBS[k]));
        chk($sformatf("sweep_y_d%0d", DBS[k]), y_a[k], ym[k]);
        chk($sformatf("sweep_cnt_d%0d", DBS[k]), {96'd0, cnt_a[k]}, 128'(cm[k]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
